// File: rtl/if_id_inst_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction queue.
// The queue side uses 'slave'; the fetch/decode side uses 'master'.
interface if_id_inst_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          flush;
    logic          push_valid;
    logic          push_ready;
    logic [31:0]   push_pc;
    logic [31:0]   push_instr;
    logic [1:0]    push_excp;
    logic          pop_valid;
    logic          pop_ready;
    logic [31:0]   pop_pc;
    logic [31:0]   pop_instr;
    logic [1:0]    pop_excp;
    logic [CW-1:0] count;

    modport master (
        output flush, push_valid, push_pc, push_instr, push_excp, pop_ready,
        input  push_ready, pop_valid, pop_pc, pop_instr, pop_excp, count
    );

    modport slave (
        input  flush, push_valid, push_pc, push_instr, push_excp, pop_ready,
        output push_ready, pop_valid, pop_pc, pop_instr, pop_excp, count
    );
endinterface

// File: rtl/if_id_inst_queue.sv
// Circular IF->ID instruction queue: one push and one pop per cycle,
// occupancy-based full/empty, cleared entirely by a redirect flush.
module if_id_inst_queue #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    if_id_inst_queue_if.slave    q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  excp;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          wr_entry;
    entry_t          head;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count_q;
    logic            push_fire;
    logic            pop_fire;

    // Ready/valid depend only on registered occupancy, never on same-cycle traffic.
    assign q.push_ready = (count_q != CW'(DEPTH));
    assign q.pop_valid  = (count_q != '0);
    assign q.count      = count_q;

    assign push_fire = q.push_valid & q.push_ready & ~q.flush;
    assign pop_fire  = q.pop_valid  & q.pop_ready  & ~q.flush;

    assign wr_entry = '{pc: q.push_pc, instr: q.push_instr, excp: q.push_excp};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (q.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + 1'b1;
            if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
            if (push_fire && !pop_fire)      count_q <= count_q + 1'b1;
            else if (pop_fire && !push_fire) count_q <= count_q - 1'b1;
        end
    end

    // Storage is not reset; an empty queue masks it at the outputs.
    always_ff @(posedge clk) begin
        if (push_fire) mem[wr_ptr] <= wr_entry;
    end

    // Empty queue presents zeros (instr 0 is a NOP) so decode never sees stale data.
    assign head        = q.pop_valid ? mem[rd_ptr] : '0;
    assign q.pop_pc    = head.pc;
    assign q.pop_instr = head.instr;
    assign q.pop_excp  = head.excp;
endmodule

// File: tb/tb_if_id_inst_queue.sv
// Scoreboard bench for if_id_inst_queue: a reference queue tracks accepted
// entries and every cycle the DUT head/count/handshake is compared against it.
module tb_if_id_inst_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    if_id_inst_queue_if #(.DEPTH(DEPTH)) qi ();

    if_id_inst_queue #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .q      (qi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  excp;
    } exp_t;

    exp_t sb [$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Compare all DUT outputs against the model state.
    task automatic chk_state(input string tag);
        exp_t h;
        h = '{pc: 32'h0, instr: 32'h0, excp: 2'b0};
        if (sb.size() != 0) h = sb[0];
        chk({tag, ".count"},      64'(qi.count),      64'(sb.size()));
        chk({tag, ".push_ready"}, 64'(qi.push_ready), 64'(sb.size() != DEPTH));
        chk({tag, ".pop_valid"},  64'(qi.pop_valid),  64'(sb.size() != 0));
        chk({tag, ".pop_pc"},     64'(qi.pop_pc),     64'(h.pc));
        chk({tag, ".pop_instr"},  64'(qi.pop_instr),  64'(h.instr));
        chk({tag, ".pop_excp"},   64'(qi.pop_excp),   64'(h.excp));
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, update model at the edge.
    task automatic cycle(input string tag, input logic pv, input logic [31:0] pc,
                         input logic [31:0] instr, input logic [1:0] excp,
                         input logic pr, input logic fl);
        bit pf, qf;
        qi.push_valid = pv;
        qi.push_pc    = pc;
        qi.push_instr = instr;
        qi.push_excp  = excp;
        qi.pop_ready  = pr;
        qi.flush      = fl;
        #4;
        chk_state(tag);
        pf = pv && (sb.size() != DEPTH) && !fl;
        qf = pr && (sb.size() != 0) && !fl;
        @(posedge clk);
        if (fl) sb.delete();
        else begin
            if (qf) void'(sb.pop_front());
            if (pf) sb.push_back('{pc: pc, instr: instr, excp: excp});
        end
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                        input logic [1:0] excp);
        cycle(tag, 1'b1, pc, instr, excp, 1'b0, 1'b0);
    endtask

    task automatic pop(input string tag);
        cycle(tag, 1'b0, 32'h0, 32'h0, 2'b0, 1'b1, 1'b0);
    endtask

    initial begin
        qi.flush = 1'b0; qi.push_valid = 1'b0; qi.push_pc = '0;
        qi.push_instr = '0; qi.push_excp = '0; qi.pop_ready = 1'b0;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk_state("por");
        resetn = 1'b1;

        // 1: asynchronous reset with three entries held
        for (int i = 0; i < 3; i++) push("t1.fill", 32'h1000 + 32'(4*i), 32'hA0 + 32'(i), 2'b0);
        chk("t1.count_before", 64'(qi.count), 64'd3);
        #2 resetn = 1'b0;
        #1;
        chk("t1.count",      64'(qi.count),      64'd0);
        chk("t1.pop_valid",  64'(qi.pop_valid),  64'd0);
        chk("t1.pop_instr",  64'(qi.pop_instr),  64'd0);
        chk("t1.push_ready", 64'(qi.push_ready), 64'd1);
        sb.delete();
        @(posedge clk);
        #1 resetn = 1'b1;

        // 2: fill to full, rejected 5th push, then drain in order
        for (int i = 0; i < 4; i++)
            push("t2.fill", 32'hBFC0_0000 + 32'(4*i), 32'h2408_0001 + 32'(i), 2'b0);
        push("t2.over", 32'hBFC0_0010, 32'h2408_0005, 2'b0);
        for (int i = 0; i < 5; i++) pop("t2.drain");

        // 3: streaming across pointer wrap
        for (int k = 0; k < 10; k++)
            cycle("t3.stream", 1'b1, 32'h8000_0000 + 32'(4*k), 32'h1234_0000 + 32'(k), 2'b0, 1'b1, 1'b0);
        pop("t3.tail");

        // 4: full with simultaneous pop; push lands the following cycle
        for (int i = 0; i < 4; i++) push("t4.fill", 32'h9000_0000 + 32'(4*i), 32'h40 + 32'(i), 2'b0);
        cycle("t4.both", 1'b1, 32'h9000_0010, 32'h44, 2'b0, 1'b1, 1'b0);
        push("t4.retry", 32'h9000_0010, 32'h44, 2'b0);
        for (int i = 0; i < 4; i++) pop("t4.drain");

        // 5: flush beats same-cycle push and pop
        push("t5.fill", 32'hBFC0_0300, 32'h51, 2'b0);
        push("t5.fill", 32'hBFC0_0304, 32'h52, 2'b0);
        cycle("t5.flush", 1'b1, 32'hBFC0_0380, 32'h53, 2'b0, 1'b1, 1'b1);
        push("t5.after", 32'hBFC0_0400, 32'h54, 2'b0);
        pop("t5.pop");
        pop("t5.idle");

        // 6: exception code travels with its entry
        push("t6.excp", 32'h8000_0002, 32'h61, 2'b01);
        push("t6.norm", 32'h8000_0004, 32'h62, 2'b00);
        pop("t6.pop");
        pop("t6.pop");
        pop("t6.idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
